// File: rtl/frankie_io_pkg.sv
// Shared sizing constants for the Frankie processor I/O path.
// The processor top level imports the same package so word width and queue depth stay in step.
package frankie_io_pkg;

    localparam int WORD_WIDTH    = 16;
    localparam int IO_FIFO_DEPTH = 8;

endpackage : frankie_io_pkg

// File: rtl/frankie_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count; the head entry is presented
// combinationally, and all-zeros are presented when the FIFO is empty.
module frankie_sync_fifo
    import frankie_io_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = IO_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A pop frees the slot, so a push to a full FIFO is accepted when it coincides with a pop.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rd_en) begin
            head_d = AW'(head_q + 1'b1);
        end
        if (wr_en) begin
            tail_d = AW'(tail_q + 1'b1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = CW'(count_q + 1'b1);
            2'b01:   count_d = CW'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // The storage array has no reset; stale contents are unreachable because count is zero.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[tail_q] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem_q[head_q];

endmodule : frankie_sync_fifo

// File: rtl/io_out_capture.sv
// Captures changes of the processor output port into a FIFO for a downstream consumer.
// Repeated writes of the same value are queued once; values that arrive while the FIFO is full are dropped, and each drop sets a sticky flag.
module io_out_capture
    import frankie_io_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = IO_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         io_out,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    logic [WIDTH-1:0] last_q, last_d;
    logic             overflow_q, overflow_d;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;

    frankie_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (io_out),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // last_q starts at zero after reset, so a non-zero port value is pushed on the first edge after reset is released.
    assign push      = (io_out != last_q);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && full && !pop;

    always_comb begin
        last_d     = io_out;
        overflow_d = overflow_q;
        if (clear_ovf) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule : io_out_capture

// File: tb/tb_io_out_capture.sv
// Scoreboard bench for io_out_capture: the driver predicts queue effects from change-capture rules,
// and a negedge monitor checks presented data and status against that prediction.
module tb_io_out_capture;

    localparam int W = 16;
    localparam int D = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  io_out = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    count;
    logic          overflow;
    logic          clear_ovf = 1'b0;

    io_out_capture #(.WIDTH(W), .DEPTH(D)) dut (
        .clock     (clock),
        .reset     (reset),
        .io_out    (io_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clock = ~clock;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] sb[$];
    int           m_cnt  = 0;
    bit           m_ovf  = 0;
    logic [W-1:0] m_last = '0;
    logic [W-1:0] last_popped = '0;
    bit           mon_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs are applied just after an edge; the effect on the queue is predicted from the rules and committed after the next edge.
    task automatic step(input logic [W-1:0] v, input logic rdy, input logic clr);
        bit do_pop, is_change, accept, dropped;
        int nxt_cnt;
        bit nxt_ovf;
        io_out    = v;
        out_ready = rdy;
        clear_ovf = clr;
        is_change = (v != m_last);
        do_pop    = rdy && (m_cnt > 0);
        accept    = is_change && (m_cnt < D || do_pop);
        dropped   = is_change && !accept;
        nxt_cnt   = m_cnt - (do_pop ? 1 : 0) + (accept ? 1 : 0);
        nxt_ovf   = dropped ? 1'b1 : (clr ? 1'b0 : m_ovf);
        @(posedge clock);
        #1;
        m_cnt  = nxt_cnt;
        m_ovf  = nxt_ovf;
        m_last = v;
        if (accept) sb.push_back(v);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            chk("count", 32'(count), 32'(m_cnt));
            chk("out_valid", 32'(out_valid), 32'(m_cnt > 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'(0), 32'(1));
                end else begin
                    chk("out_data", 32'(out_data), 32'(sb[0]));
                    if (out_ready) last_popped = sb.pop_front();
                end
            end else begin
                chk("out_data_empty", 32'(out_data), 32'(0));
            end
        end
    end

    initial begin
        logic [W-1:0] v;
        @(posedge clock);
        #1;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        reset  = 1'b1;
        mon_en = 1;

        // Constant zero after reset never pushes.
        for (int i = 0; i < 5; i++) begin
            step(16'h0000, 1'b0, 1'b0);
            chk("idle_valid", 32'(out_valid), 32'(0));
            chk("idle_count", 32'(count), 32'(0));
        end

        // Two changes queued, then drained in order.
        step(16'h0007, 1'b0, 1'b0);
        step(16'h000C, 1'b0, 1'b0);
        chk("two_count", 32'(count), 32'(2));
        chk("two_head", 32'(out_data), 32'h7);
        step(16'h000C, 1'b1, 1'b0);
        chk("two_second", 32'(out_data), 32'hC);
        step(16'h000C, 1'b1, 1'b0);
        chk("two_empty", 32'(out_valid), 32'(0));

        // Nine distinct values into depth eight: last one dropped.
        for (int i = 0; i < 9; i++) step(16'(16'h0100 + i), 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'(8));
        chk("full_ovf", 32'(overflow), 32'(1));
        chk("full_head", 32'(out_data), 32'h0100);
        step(16'h0108, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'(0));

        // Full queue with simultaneous pop and push: push is accepted, overflow stays clear.
        step(16'h1234, 1'b1, 1'b0);
        chk("fullpp_count", 32'(count), 32'(8));
        chk("fullpp_ovf", 32'(overflow), 32'(0));
        for (int i = 0; i < 10; i++) step(16'h1234, 1'b1, 1'b0);
        chk("fullpp_last", 32'(last_popped), 32'h1234);
        chk("fullpp_drained", 32'(out_valid), 32'(0));

        // Reset asserted between edges drops status at once.
        step(16'h0021, 1'b0, 1'b0);
        step(16'h0022, 1'b0, 1'b0);
        step(16'h0023, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'(3));
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'(0));
        chk("async_count", 32'(count), 32'(0));
        chk("async_data", 32'(out_data), 32'(0));
        m_cnt = 0; m_ovf = 0; m_last = '0; sb.delete();
        io_out = 16'h0005;
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(16'h0005, 1'b0, 1'b0);
        chk("post_rst_count", 32'(count), 32'(1));
        chk("post_rst_data", 32'(out_data), 32'h5);
        step(16'h0005, 1'b1, 1'b0);
        chk("post_rst_last", 32'(last_popped), 32'h5);

        // Held value is captured once.
        for (int i = 0; i < 20; i++) step(16'h0037, 1'b0, 1'b0);
        chk("hold_count", 32'(count), 32'(1));
        step(16'h0037, 1'b1, 1'b0);

        // Simultaneous push and pop walks the pointers well past the depth.
        for (int i = 0; i < 20; i++) step(16'(16'h0200 + i), 1'b1, 1'b0);
        step(16'h0213, 1'b1, 1'b0);
        chk("wrap_last", 32'(last_popped), 32'h0213);
        chk("wrap_empty", 32'(count), 32'(0));

        // Random traffic over a small value alphabet so repeats and overflows both occur.
        for (int i = 0; i < 1500; i++) begin
            v = 16'($urandom_range(0, 3));
            step(v, (i % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < D + 2; i++) step(io_out, 1'b1, 1'b0);
        chk("final_sb_empty", 32'(sb.size()), 32'(0));
        chk("final_count", 32'(count), 32'(0));

        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_io_out_capture

// File: doc/io_out_capture.md
IO_OUT_CAPTURE -- requirements
Module: io_out_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the bit width of the processor output port and of each queued entry.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of FIFO entries; it SHALL be a power of two, at least 2.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port io_out, input, WIDTH bits: the processor output port value, sampled every cycle.
REQ-006 SHALL have port out_data, output, WIDTH bits: the head-of-queue value.
REQ-007 SHALL have port out_valid, output, 1 bit: high when the queue is non-empty.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the head this cycle.
REQ-009 SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of entries currently held.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag meaning at least one change was dropped.
REQ-011 SHALL have port clear_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-012 SHALL hold last_q, a WIDTH-bit copy of io_out, reloaded every rising edge.
REQ-013 SHALL assert push when io_out != last_q, evaluated combinationally before the edge.
REQ-014 SHALL assert pop when out_valid && out_ready.
REQ-015 SHALL, on push with the queue not full, write io_out at the tail on that edge; out_valid SHALL be high in the following cycle, with a latency of 1 edge and no combinational bypass.
REQ-016 SHALL, on pop, advance the head on that edge; the next entry or empty status SHALL be visible in the following cycle.
REQ-017 SHALL drive out_data to mem[head] when non-empty and to all-zeros when empty.
REQ-018 SHALL, on simultaneous push and pop when non-empty, perform both; count SHALL be unchanged.
REQ-019 SHALL, on simultaneous push and pop when full, accept the push because the pop frees the slot; overflow SHALL be unchanged.
REQ-020 SHALL, on push when full and no pop, drop the new value, leave the queue unchanged and set overflow.
REQ-021 SHALL ignore out_ready when empty, with no pointer change.
REQ-022 SHALL have head and tail pointers that wrap modulo DEPTH; count SHALL range from 0 to DEPTH inclusive.
REQ-023 SHALL clear overflow on clear_ovf; if a drop occurs in the same cycle, set SHALL win.
REQ-024 SHALL queue two identical consecutive writes by the processor only once, because it captures changes and not writes.

Reset
REQ-025 SHALL, while reset is low, immediately force last_q=0, head=0, tail=0, count=0, overflow=0, out_valid=0 and out_data=0.
REQ-026 SHALL discard all queued data when reset is asserted mid-operation; no partial write SHALL survive.
REQ-027 SHALL, in the first edge after release, push io_out if it is non-zero, because it is compared against last_q=0.

Structure
REQ-028 SHALL take WORD_WIDTH=16 and IO_FIFO_DEPTH=8 as localparams from shared package frankie_io_pkg, which is shared with the processor top level.
REQ-029 SHALL place its storage and pointers in one sub-module, frankie_sync_fifo, which has push/pop/full/empty/count; change detection and overflow logic SHALL stay in io_out_capture.

Verification
REQ-030 SHALL be verified by this scenario: after reset, io_out=16'h0000 held for 5 cycles -> out_valid=0, count=0 throughout.
REQ-031 SHALL be verified by this scenario: io_out steps 0 -> 16'h0007 -> 16'h000C on consecutive cycles with out_ready=0 -> count=2; then out_ready=1 -> out_data 7, then 12, then out_valid=0.
REQ-032 SHALL be verified by this scenario: with DEPTH=8 and out_ready=0, 9 distinct values are driven on consecutive cycles -> count=8, overflow=1, the 9th value is absent; then clear_ovf=1 for one cycle -> overflow=0.
REQ-033 SHALL be verified by this scenario: the queue is full, out_ready=1 and a new value 16'h1234 arrive in the same cycle -> count stays 8, overflow=0, 16'h1234 is the last entry popped.
REQ-034 SHALL be verified by this scenario: 3 entries are queued, then reset is pulsed low mid-cycle -> out_valid and count drop to 0 immediately, before the next edge; with io_out=16'h0005 held at release -> exactly one push of 5.
REQ-035 SHALL be verified by this scenario: io_out held at 16'h0037 for 20 cycles after one change -> exactly one entry, with wrap-around checked by 20 push/pop pairs at DEPTH=8.
